// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operation request from the master,
// busy/done status and the registered result pair from the slave.
interface seq_alu_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;

  modport master (
    output start, op, src_a, src_b,
    input  busy, done, result, result_hi
  );

  modport slave (
    input  start, op, src_a, src_b,
    output busy, done, result, result_hi
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops plus WIDTH-cycle FILL, MULU and DIVU.
// Define SEQ_ALU_DIV_EN to build the restoring divider (op 9); otherwise op 9 returns zero.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  seq_alu_if.slave   bus
);

  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_ORI  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_LUI  = 4'd4;
  localparam logic [3:0] OP_FILL = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_MULU = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] opnd_q, hi_q, lo_q;
  logic [SHW-1:0]   cnt_q;
  logic             done_q;
  logic [WIDTH-1:0] res_q, res_hi_q;

  logic             accept, last, is_multi;
  logic [3:0]       cur_op;
  logic [WIDTH-1:0] cur_opnd, cur_hi, cur_lo;
  logic [WIDTH-1:0] nxt_opnd, nxt_hi, nxt_lo;
  logic [WIDTH-1:0] quick_res;
  logic [WIDTH:0]   sum;
  logic             fill_bit;
`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0]   rem_sh, diff;
  logic             ge;
`endif

  assign accept = bus.start && (state_q == IDLE);
  assign last   = (state_q == RUN) && (cnt_q == SHW'(WIDTH - 1));

  always_comb begin
    is_multi = (bus.op == OP_FILL) || (bus.op == OP_MULU);
`ifdef SEQ_ALU_DIV_EN
    is_multi = is_multi || (bus.op == OP_DIVU);
`endif
  end

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_multi) state_d = RUN;
      RUN:  if (last)               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    quick_res = '0;
    case (bus.op)
      OP_SLL: quick_res = bus.src_a << bus.src_b[SHW-1:0];
      OP_SUB: quick_res = bus.src_a - bus.src_b;
      OP_ORI: quick_res = bus.src_a | {{(WIDTH-16){1'b0}}, bus.src_b[15:0]};
      OP_ADD: quick_res = bus.src_a + bus.src_b;
      OP_LUI: quick_res = bus.src_b << 16;
      OP_SRL: quick_res = bus.src_a >> bus.src_b[SHW-1:0];
      OP_SRA: quick_res = $unsigned($signed(bus.src_a) >>> bus.src_b[SHW-1:0]);
      default: quick_res = '0;
    endcase
  end

  // Iteration 0 runs on the accept edge straight from the ports, so the
  // remaining WIDTH-1 iterations fit in the RUN cycles.
  always_comb begin
    cur_op   = op_q;
    cur_opnd = opnd_q;
    cur_hi   = hi_q;
    cur_lo   = lo_q;
    if (state_q == IDLE) begin
      cur_op   = bus.op;
      cur_opnd = bus.src_a;
      cur_hi   = '0;
      cur_lo   = bus.src_b;
      if (bus.op == OP_FILL) begin
        cur_hi = bus.src_b;
        cur_lo = '0;
      end
`ifdef SEQ_ALU_DIV_EN
      if (bus.op == OP_DIVU) begin
        cur_opnd = bus.src_b;
        cur_lo   = bus.src_a;
      end
`endif
    end
  end

  always_comb begin
    nxt_opnd = cur_opnd;
    nxt_hi   = cur_hi;
    nxt_lo   = cur_lo;
    sum      = '0;
    fill_bit = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    rem_sh   = '0;
    diff     = '0;
    ge       = 1'b0;
`endif
    case (cur_op)
      OP_FILL: begin
        // Result shifts in from the MSB so bit i lands at position i after WIDTH steps.
        if (cur_opnd[0]) begin
          fill_bit = 1'b1;
        end else if (cur_hi != '0) begin
          fill_bit = 1'b1;
          nxt_hi   = cur_hi - 1'b1;
        end
        nxt_opnd = cur_opnd >> 1;
        nxt_lo   = {fill_bit, cur_lo[WIDTH-1:1]};
      end
      OP_MULU: begin
        sum    = {1'b0, cur_hi} + (cur_lo[0] ? {1'b0, cur_opnd} : '0);
        nxt_hi = sum[WIDTH:1];
        nxt_lo = {sum[0], cur_lo[WIDTH-1:1]};
      end
`ifdef SEQ_ALU_DIV_EN
      OP_DIVU: begin
        // A zero divisor always "fits", yielding all-ones quotient and remainder = A.
        rem_sh = {cur_hi, cur_lo[WIDTH-1]};
        diff   = rem_sh - {1'b0, cur_opnd};
        ge     = rem_sh >= {1'b0, cur_opnd};
        nxt_hi = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        nxt_lo = {cur_lo[WIDTH-2:0], ge};
      end
`endif
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      res_q    <= '0;
      res_hi_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept) begin
        op_q   <= bus.op;
        opnd_q <= nxt_opnd;
        hi_q   <= nxt_hi;
        lo_q   <= nxt_lo;
        cnt_q  <= SHW'(1);
        if (!is_multi) begin
          res_q    <= quick_res;
          res_hi_q <= '0;
          done_q   <= 1'b1;
        end
      end else if (state_q == RUN) begin
        if (last) begin
          res_q    <= nxt_lo;
          res_hi_q <= (op_q == OP_FILL) ? '0 : nxt_hi;
          done_q   <= 1'b1;
          cnt_q    <= '0;
        end else begin
          opnd_q <= nxt_opnd;
          hi_q   <= nxt_hi;
          lo_q   <= nxt_lo;
          cnt_q  <= cnt_q + SHW'(1);
        end
      end
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.result_hi = res_hi_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=32; follows SEQ_ALU_DIV_EN
// to select the expected behaviour of op 9.
module tb_seq_alu;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc, nbusy;
  logic held;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) bus ();

  seq_alu #(.WIDTH(32), .SHW(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request through its accept edge; returns in cycle N+1.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Waits (bounded) for done, counting busy cycles; optionally pulses an ADD
  // request at cycle pulse_at, and tracks whether result stayed untouched meanwhile.
  task automatic wait_done(input int from, input int pulse_at, output int c,
                           output int nb, output logic hold);
    logic [31:0] snap;
    snap = bus.result;
    hold = 1'b1;
    c    = from;
    nb   = 0;
    while (bus.done !== 1'b1 && c < 200) begin
      if (bus.busy === 1'b1) nb++;
      if (bus.result !== snap) hold = 1'b0;
      if (c == pulse_at) begin
        bus.start = 1'b1;
        bus.op    = 4'd3;
        bus.src_a = 32'd1;
        bus.src_b = 32'd1;
      end
      tick();
      bus.start = 1'b0;
      c++;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = '0;
    bus.src_a = '0;
    bus.src_b = '0;

    // Reset state
    tick();
    tick();
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_result", bus.result, 32'h0);
    check("rst_result_hi", bus.result_hi, 32'h0);
    reset_n = 1'b1;
    tick();

    // Single-cycle ops
    issue(4'd3, 32'h7FFF_FFFF, 32'h1);
    check("add_done", bus.done, 1'b1);
    check("add_busy", bus.busy, 1'b0);
    check("add_res", bus.result, 32'h8000_0000);
    check("add_hi", bus.result_hi, 32'h0);
    tick();
    check("add_done_pulse", bus.done, 1'b0);

    issue(4'd7, 32'h8000_0000, 32'd4);
    check("sra_res", bus.result, 32'hF800_0000);
    issue(4'd6, 32'h8000_0000, 32'd4);
    check("srl_res", bus.result, 32'h0800_0000);
    issue(4'd0, 32'h0000_0001, 32'h0000_0023);
    check("sll_mask_res", bus.result, 32'h0000_0008);
    issue(4'd1, 32'h0, 32'h1);
    check("sub_wrap_res", bus.result, 32'hFFFF_FFFF);
    issue(4'd2, 32'hF000_0000, 32'hFFFF_1234);
    check("ori_res", bus.result, 32'hF000_1234);
    issue(4'd4, 32'hDEAD_BEEF, 32'h1234_ABCD);
    check("lui_res", bus.result, 32'hABCD_0000);
    issue(4'd12, 32'h1234_5678, 32'h9ABC_DEF0);
    check("op12_done", bus.done, 1'b1);
    check("op12_res", bus.result, 32'h0);
    check("op12_hi", bus.result_hi, 32'h0);
    tick();

    // FILL
    issue(4'd5, 32'h0000_0005, 32'd3);
    wait_done(1, 0, cyc, nbusy, held);
    check("fill1_lat", cyc, 32);
    check("fill1_busy_cycles", nbusy, 31);
    check("fill1_busy_at_done", bus.busy, 1'b0);
    check("fill1_res", bus.result, 32'h0000_001F);
    check("fill1_hi", bus.result_hi, 32'h0);
    tick();
    issue(4'd5, 32'h0, 32'd40);
    wait_done(1, 0, cyc, nbusy, held);
    check("fill2_lat", cyc, 32);
    check("fill2_res", bus.result, 32'hFFFF_FFFF);
    tick();

    // MULU with an ignored start mid-run
    issue(4'd8, 32'hFFFF_FFFF, 32'h2);
    wait_done(1, 5, cyc, nbusy, held);
    check("mul_lat", cyc, 32);
    check("mul_busy_cycles", nbusy, 31);
    check("mul_result_held", held, 1'b1);
    check("mul_res", bus.result, 32'hFFFF_FFFE);
    check("mul_hi", bus.result_hi, 32'h1);
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) nbusy++;
    end
    check("mul_single_done", nbusy, 0);

    // DIVU
`ifdef SEQ_ALU_DIV_EN
    issue(4'd9, 32'd100, 32'd7);
    wait_done(1, 0, cyc, nbusy, held);
    check("div_lat", cyc, 32);
    check("div_q", bus.result, 32'd14);
    check("div_r", bus.result_hi, 32'd2);
    tick();
    issue(4'd9, 32'd100, 32'd0);
    wait_done(1, 0, cyc, nbusy, held);
    check("div0_lat", cyc, 32);
    check("div0_q", bus.result, 32'hFFFF_FFFF);
    check("div0_r", bus.result_hi, 32'd100);
`else
    issue(4'd9, 32'd100, 32'd7);
    check("div_off_done", bus.done, 1'b1);
    check("div_off_busy", bus.busy, 1'b0);
    check("div_off_q", bus.result, 32'd0);
    check("div_off_r", bus.result_hi, 32'd0);
`endif
    tick();

    // Reset during MULU, with start held high while in reset
    issue(4'd8, 32'd3, 32'd5);
    for (int i = 0; i < 9; i++) tick();
    reset_n   = 1'b0;
    bus.start = 1'b1;
    bus.op    = 4'd3;
    bus.src_a = 32'd1;
    bus.src_b = 32'd2;
    tick();
    check("rstmid_busy", bus.busy, 1'b0);
    check("rstmid_done", bus.done, 1'b0);
    check("rstmid_res", bus.result, 32'h0);
    check("rstmid_hi", bus.result_hi, 32'h0);
    tick();
    check("rst_start_ignored", bus.done, 1'b0);
    bus.start = 1'b0;
    reset_n   = 1'b1;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) nbusy++;
    end
    check("rstmid_no_late_done", nbusy, 0);

    // Back-to-back: ADD issued in the MULU done cycle
    issue(4'd8, 32'd3, 32'd5);
    wait_done(1, 0, cyc, nbusy, held);
    check("b2b_mul_lat", cyc, 32);
    check("b2b_mul_res", bus.result, 32'd15);
    issue(4'd3, 32'd2, 32'd3);
    check("b2b_add_done", bus.done, 1'b1);
    check("b2b_add_busy", bus.busy, 1'b0);
    check("b2b_add_res", bus.result, 32'd5);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal range 16..64.
REQ-002 SHALL have parameter SHW, default 5, shift-amount width, equal to clog2(WIDTH).
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port start, input, 1, request; accepted only when busy=0.
REQ-006 SHALL have port op, input, 4, operation code, sampled at accept.
REQ-007 SHALL have ports src_a and src_b, input, WIDTH each, operands, sampled at accept.
REQ-008 SHALL have port busy, output, 1, high while a multi-cycle operation runs.
REQ-009 SHALL have port done, output, 1, one-cycle pulse marking result and result_hi valid.
REQ-010 SHALL have ports result and result_hi, output, WIDTH each, registered results, held until the next done.

Function
REQ-011 SHALL accept a request at edge N when start=1 and busy=0; start with busy=1 SHALL be ignored without side effects.
REQ-012 SHALL implement op 0 SLL, A<<B[SHW-1:0]; op 1 SUB, A-B; op 2 ORI, A|zext(B[15:0]); op 3 ADD, A+B; op 4 LUI, B<<16; op 6 SRL, logical right shift; op 7 SRA, arithmetic right shift; all wrap modulo 2^WIDTH, with result_hi=0.
REQ-013 SHALL implement the REQ-012 ops with latency 1: done=1 in cycle N+1 and busy never asserted.
REQ-014 SHALL implement op 5 FILL over WIDTH cycles, one bit per cycle from LSB upward, with a down-counter loaded from B: bit i=1 if A[i]=1; else bit i=1 and counter decrements if counter>0; else bit i=0. result_hi SHALL be 0.
REQ-015 SHALL implement op 8 MULU as unsigned shift-add over WIDTH cycles: {result_hi,result}=A*B.
REQ-016 SHALL implement op 9 DIVU as unsigned restoring division over WIDTH cycles: result=quotient, result_hi=remainder; if B=0, quotient SHALL be all ones and remainder SHALL be A.
REQ-017 SHALL give multi-cycle ops busy=1 in cycles N+1..N+WIDTH-1 and done=1 with busy=0 in cycle N+WIDTH.
REQ-018 SHALL allow a new start in the done cycle (back-to-back, no bubble).
REQ-019 SHALL treat op 10..15 as 1-cycle ops with result=0 and result_hi=0.
REQ-020 SHALL use FSM states IDLE and RUN: IDLE->RUN on accepted multi-cycle op; RUN->IDLE when iteration counter reaches WIDTH-1; 1-cycle ops stay in IDLE.
REQ-021 SHALL leave result and result_hi unchanged during RUN, updating both only in the done cycle.

Reset
REQ-022 SHALL, on a rising edge with reset_n=0, set state IDLE, busy=0, done=0, result=0, result_hi=0, and all counters to 0.
REQ-023 SHALL abort an in-flight operation on reset without producing a done pulse, and SHALL ignore start while reset_n=0.

Configuration
REQ-024 SHALL, with SEQ_ALU_DIV_EN defined, compile in DIVU per REQ-016.
REQ-025 SHALL, with SEQ_ALU_DIV_EN undefined, omit the divider logic and treat op 9 as a 1-cycle op returning result=0 and result_hi=0.

Verification (WIDTH=32)
REQ-026 SHALL check: ADD 0x7FFFFFFF+0x1 -> result=0x80000000, done at N+1, busy=0 throughout; SRA 0x80000000 by 4 -> 0xF8000000.
REQ-027 SHALL check: FILL A=0x00000005, B=3 -> result=0x0000001F, done at N+32; FILL A=0, B=40 -> 0xFFFFFFFF.
REQ-028 SHALL check: MULU 0xFFFFFFFF*0x2 -> result_hi=0x1, result=0xFFFFFFFE, busy high N+1..N+31; start pulsed at N+5 -> ignored, single done.
REQ-029 SHALL check, with macro defined: DIVU 100/7 -> result=14, result_hi=2; DIVU 100/0 -> 0xFFFFFFFF, 100. With macro undefined: DIVU 100/7 -> 0, 0 at N+1.
REQ-030 SHALL check: reset_n=0 at N+10 of MULU -> next edge busy=0, done=0, results 0, no later done; back-to-back ADD issued in a MULU done cycle -> done at following cycle.
